dm_stage: RTL

- MEM-stage data memory with load extension, placed between the EX/MEM register and the MEM/WB register.
- Takes the ALU address and the forwarded store data from EX/MEM, and performs word, half and byte stores into a word-organised RAM.
- Produces sign- or zero-extended load data. This data is the RD input of the MEM/WB register, which captures it on the next edge.
- Flags misaligned or out-of-range accesses for the exception logic.

---
 rtl/dm_stage.sv | 73 +++++++
 1 files changed

// File: rtl/dm_stage.sv
// dm_stage: MEM-stage data memory with lane-merged stores, extended loads and address-error flags.
// Loads are combinational from the current array contents; stores commit on the rising edge.
module dm_stage #(
    parameter int          WORDS     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter bit          TRACE     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_M,
    input  logic [31:0] Addr_M,
    input  logic [31:0] WD_M,
    input  logic        MemRead_M,
    input  logic        MemWrite_M,
    input  logic [1:0]  MemSize_M,
    input  logic        MemSign_M,
    output logic [31:0] RD_M,
    output logic        AdEL_M,
    output logic        AdES_M
);
    localparam int AW = $clog2(WORDS);
    localparam logic [32:0] LIMIT = 33'(WORDS) * 33'd4;

    logic [31:0]   mem [WORDS];
    logic [31:0]   off, word, ext, wmask, wdata, merged;
    logic [15:0]   half;
    logic [7:0]    bt;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          in_range, misal, we;

    assign off      = Addr_M - BASE_ADDR;
    assign idx      = off[AW+1:2];
    assign lane     = off[1:0];
    assign in_range = {1'b0, off} < LIMIT;
    assign misal    = (MemSize_M == 2'd3) || (MemSize_M == 2'd0 && lane != 2'd0) ||
                      (MemSize_M == 2'd1 && lane[0]);
    assign AdEL_M   = MemRead_M & (misal | ~in_range);
    assign AdES_M   = MemWrite_M & (misal | ~in_range);
    assign we       = MemWrite_M & ~AdES_M;
    assign word     = mem[idx];

    always_comb begin
        half  = lane[1] ? word[31:16] : word[15:0];
        bt    = word[{lane, 3'b000} +: 8];
        ext   = MemSize_M == 2'd0 ? word :
                MemSize_M == 2'd1 ? {{16{MemSign_M & half[15]}}, half} :
                                    {{24{MemSign_M & bt[7]}}, bt};
        RD_M  = (MemRead_M && !AdEL_M) ? ext : 32'h0;
        wmask = MemSize_M == 2'd0 ? 32'hFFFF_FFFF :
                MemSize_M == 2'd1 ? (lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) :
                                    32'h0000_00FF << {lane, 3'b000};
        wdata = MemSize_M == 2'd0 ? WD_M :
                MemSize_M == 2'd1 ? {2{WD_M[15:0]}} : {4{WD_M[7:0]}};
        merged = (word & ~wmask) | (wdata & wmask);
    end

    // A store presented during reset is dropped because the clear takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= 32'h0;
        end else if (we) begin
            mem[idx] <= merged;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (TRACE && !reset && we)
            $write("%0t@%h: *%h <= %h\n", $time, PC_M, {Addr_M[31:2], 2'b00}, merged);
    end
`endif
endmodule
